// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared UART defaults, state encoding and bit-timing helpers.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int unsigned DEF_CLK_FREQ  = 27_000_000;
  localparam int unsigned DEF_BOUD_RATE = 9600;
  localparam int unsigned DATA_BITS     = 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_t;

  function automatic int unsigned calc_cycle(input int unsigned clk_freq,
                                             input int unsigned baud);
    return clk_freq / baud;
  endfunction

  function automatic int unsigned calc_half(input int unsigned clk_freq,
                                            input int unsigned baud);
    return (clk_freq / baud) / 2;
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_if
// Brief    : Serial line input and decoded byte outputs of the UART receiver.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_rx_if;
  logic       rx_pin;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx_pin, input data, valid, frame_err, busy);
  modport slave  (input rx_pin, output data, valid, frame_err, busy);
endinterface
`default_nettype wire

// File: rtl/uart_rx_sync.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_sync
// Brief    : 2-FF synchroniser, falling-edge detect and sample selection.
//            Optional 3-tap majority filter: UART_RX_MAJORITY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_sync (
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic rx_pin,
  output logic      sample,
  output logic      fall_edge
);

  logic r_meta;
  logic r_rx_s;
  logic r_rx_d;

  // Flops reset to 1 so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b1;
      r_rx_s <= 1'b1;
      r_rx_d <= 1'b1;
    end else begin
      r_meta <= rx_pin;
      r_rx_s <= r_meta;
      r_rx_d <= r_rx_s;
    end
  end

  assign fall_edge = r_rx_d & ~r_rx_s;

`ifdef UART_RX_MAJORITY_EN
  logic r_rx_d2;

  always_ff @(posedge clk) begin
    if (!rst_n) r_rx_d2 <= 1'b1;
    else        r_rx_d2 <= r_rx_d;
  end

  assign sample = (r_rx_s & r_rx_d) | (r_rx_s & r_rx_d2) | (r_rx_d & r_rx_d2);
`else
  assign sample = r_rx_s;
`endif

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx
// Brief    : 8N1 UART receiver, mid-bit sampling, valid/frame_err pulses.
//            Optional majority filter via UART_RX_MAJORITY_EN (in uart_rx_sync).
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = DEF_CLK_FREQ,
  parameter int unsigned BOUD_RATE = DEF_BOUD_RATE
) (
  input wire logic  clk,
  input wire logic  rst_n,
  uart_rx_if.slave  rx_if
);

  localparam logic [15:0] c_cycle_last = 16'(calc_cycle(CLK_FREQ, BOUD_RATE) - 1);
  localparam logic [15:0] c_half_last  = 16'(calc_half(CLK_FREQ, BOUD_RATE) - 1);
  localparam logic [3:0]  c_last_bit   = 4'(DATA_BITS - 1);

  logic w_sample;
  logic w_fall_edge;

  uart_rx_sync u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_pin    (rx_if.rx_pin),
    .sample    (w_sample),
    .fall_edge (w_fall_edge)
  );

  uart_state_t r_state, w_state;
  logic [15:0] r_cycle, w_cycle;
  logic [3:0]  r_bit,   w_bit;
  logic [7:0]  r_shift, w_shift;
  logic [7:0]  r_data,  w_data;
  logic        r_valid, w_valid;
  logic        r_frame_err, w_frame_err;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cycle     <= '0;
      r_bit       <= '0;
      r_shift     <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_cycle     <= w_cycle;
      r_bit       <= w_bit;
      r_shift     <= w_shift;
      r_data      <= w_data;
      r_valid     <= w_valid;
      r_frame_err <= w_frame_err;
    end
  end

  always_comb begin
    w_state     = r_state;
    w_cycle     = r_cycle + 16'd1;
    w_bit       = r_bit;
    w_shift     = r_shift;
    w_data      = r_data;
    w_valid     = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cycle = '0;
        if (w_fall_edge) w_state = S_START;
      end
      S_START: begin
        // Half a bit in: a line already back high was only a glitch.
        if (r_cycle == c_half_last) begin
          w_cycle = '0;
          if (!w_sample) begin
            w_bit   = '0;
            w_state = S_DATA;
          end else begin
            w_state = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (r_cycle == c_cycle_last) begin
          w_cycle             = '0;
          w_shift[r_bit[2:0]] = w_sample;
          if (r_bit == c_last_bit) w_state = S_STOP;
          else                     w_bit   = r_bit + 4'd1;
        end
      end
      S_STOP: begin
        if (r_cycle == c_cycle_last) begin
          w_cycle = '0;
          w_state = S_IDLE;
          if (w_sample) begin
            w_data  = r_shift;
            w_valid = 1'b1;
          end else begin
            w_frame_err = 1'b1;
          end
        end
      end
      default: w_state = S_IDLE;
    endcase
  end

  assign rx_if.data      = r_data;
  assign rx_if.valid     = r_valid;
  assign rx_if.frame_err = r_frame_err;
  assign rx_if.busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx
// Brief    : Directed self-checking bench for uart_rx (CYCLE=16, HALF=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  localparam int CYCLE = 16;
  localparam int HALF  = 8;
  localparam int FRAME = 10 * CYCLE;
  // Line change to edge-detect takes 3 posedges (meta, rx_s, rx_d).
  localparam int LAT   = 3 + HALF + 9 * CYCLE;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  uart_rx_if rx_if ();

  uart_rx #(
    .CLK_FREQ  (160),
    .BOUD_RATE (10)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .rx_if (rx_if.slave)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  int         n_valid = 0;
  int         n_ferr  = 0;
  int         n_both  = 0;
  logic [7:0] pulse_data [0:31];
  int         pulse_cyc  [0:31];

  always @(negedge clk) begin
    if (rx_if.valid) begin
      if (n_valid < 32) begin
        pulse_data[n_valid] <= rx_if.data;
        pulse_cyc[n_valid]  <= cyc;
      end
      n_valid <= n_valid + 1;
    end
    if (rx_if.frame_err) n_ferr <= n_ferr + 1;
    if (rx_if.valid && rx_if.frame_err) n_both <= n_both + 1;
  end

  // Drives one 8N1 frame, one line value per clock; optional one-cycle
  // inversion at glitch_i and optional reset (with line idle) at abort_i.
  task automatic send_frame(input logic [7:0] b, input logic stop,
                            input int glitch_i, input int abort_i,
                            output int start_cyc);
    int   bp;
    logic v;
    start_cyc = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      if (i == 0) start_cyc = cyc;
      if (i == abort_i) begin
        rst_n        = 1'b0;
        rx_if.rx_pin = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      bp = i / CYCLE;
      if (bp == 0)      v = 1'b0;
      else if (bp == 9) v = stop;
      else              v = b[bp-1];
      if (i == glitch_i) v = ~v;
      rx_if.rx_pin = v;
    end
  endtask

  task automatic test_reset;
    rx_if.rx_pin = 1'b1;
    rst_n        = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (rx_if.data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", rx_if.data); end
    checks++; if (rx_if.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rx_if.valid); end
    checks++; if (rx_if.frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", rx_if.frame_err); end
    checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", rx_if.busy); end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_loopback;
    int v0, f0, sc;
    logic busy_mid;
    v0 = n_valid; f0 = n_ferr;
    fork
      send_frame(8'hA5, 1'b1, -1, -1, sc);
      begin repeat (CYCLE * 5) @(negedge clk); busy_mid = rx_if.busy; end
    join
    checks++; if (busy_mid !== 1'b1) begin errors++; $display("FAIL loop_busy got %b exp 1", busy_mid); end
    checks++; if (n_valid - v0 != 1) begin errors++; $display("FAIL loop_count got %0d exp 1", n_valid - v0); end
    checks++; if (pulse_data[v0] !== 8'hA5) begin errors++; $display("FAIL loop_data got %h exp a5", pulse_data[v0]); end
    checks++; if (pulse_cyc[v0] - sc != LAT) begin errors++; $display("FAIL loop_latency got %0d exp %0d", pulse_cyc[v0] - sc, LAT); end
    checks++; if (n_ferr != f0) begin errors++; $display("FAIL loop_ferr got %0d exp 0", n_ferr - f0); end
    checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL loop_idle_busy got %b exp 0", rx_if.busy); end
  endtask

  task automatic test_back_to_back;
    int v0, sc;
    v0 = n_valid;
    send_frame(8'h00, 1'b1, -1, -1, sc);
    send_frame(8'hFF, 1'b1, -1, -1, sc);
    repeat (2) @(negedge clk);
    checks++; if (n_valid - v0 != 2) begin errors++; $display("FAIL b2b_count got %0d exp 2", n_valid - v0); end
    checks++; if (pulse_data[v0] !== 8'h00) begin errors++; $display("FAIL b2b_data0 got %h exp 00", pulse_data[v0]); end
    checks++; if (pulse_data[v0+1] !== 8'hFF) begin errors++; $display("FAIL b2b_data1 got %h exp ff", pulse_data[v0+1]); end
    checks++; if (pulse_cyc[v0+1] - pulse_cyc[v0] != FRAME) begin errors++; $display("FAIL b2b_spacing got %0d exp %0d", pulse_cyc[v0+1] - pulse_cyc[v0], FRAME); end
  endtask

  task automatic test_false_start;
    int v0, f0;
    logic b_last_high, b_first_low;
    v0 = n_valid; f0 = n_ferr;
    b_last_high = 1'b0; b_first_low = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rx_if.rx_pin = (i < 4) ? 1'b0 : 1'b1;
      if (i == HALF + 2) b_last_high = rx_if.busy;
      if (i == HALF + 3) b_first_low = rx_if.busy;
    end
    checks++; if (b_last_high !== 1'b1) begin errors++; $display("FAIL fs_busy_high got %b exp 1", b_last_high); end
    checks++; if (b_first_low !== 1'b0) begin errors++; $display("FAIL fs_busy_drop got %b exp 0", b_first_low); end
    checks++; if (n_valid != v0) begin errors++; $display("FAIL fs_valid got %0d exp 0", n_valid - v0); end
    checks++; if (n_ferr != f0) begin errors++; $display("FAIL fs_ferr got %0d exp 0", n_ferr - f0); end
  endtask

  task automatic test_frame_error;
    int v0, f0, sc;
    logic [7:0] prev;
    v0 = n_valid; f0 = n_ferr; prev = rx_if.data;
    send_frame(8'h55, 1'b0, -1, -1, sc);
    repeat (3 * CYCLE) @(negedge clk);
    rx_if.rx_pin = 1'b1;
    repeat (CYCLE) @(negedge clk);
    checks++; if (n_ferr - f0 != 1) begin errors++; $display("FAIL fe_count got %0d exp 1", n_ferr - f0); end
    checks++; if (n_valid != v0) begin errors++; $display("FAIL fe_valid got %0d exp 0", n_valid - v0); end
    checks++; if (rx_if.data !== prev) begin errors++; $display("FAIL fe_data_hold got %h exp %h", rx_if.data, prev); end
    send_frame(8'h3C, 1'b1, -1, -1, sc);
    repeat (2) @(negedge clk);
    checks++; if (n_valid - v0 != 1 || rx_if.data !== 8'h3C) begin errors++; $display("FAIL fe_recover got %h exp 3c", rx_if.data); end
  endtask

  task automatic test_reset_mid_frame;
    int v0, f0, sc;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h81, 1'b1, -1, 4 * CYCLE + 4, sc);
    repeat (2 * CYCLE) @(negedge clk);
    checks++; if (rx_if.data !== 8'h00) begin errors++; $display("FAIL rmf_data got %h exp 00", rx_if.data); end
    checks++; if (rx_if.busy !== 1'b0) begin errors++; $display("FAIL rmf_busy got %b exp 0", rx_if.busy); end
    checks++; if (n_valid != v0 || n_ferr != f0) begin errors++; $display("FAIL rmf_pulses got %0d exp 0", (n_valid - v0) + (n_ferr - f0)); end
    send_frame(8'h42, 1'b1, -1, -1, sc);
    repeat (2) @(negedge clk);
    checks++; if (n_valid - v0 != 1 || rx_if.data !== 8'h42) begin errors++; $display("FAIL rmf_next got %h exp 42", rx_if.data); end
  endtask

  task automatic test_glitch;
    int sc;
    logic [7:0] exp_d;
`ifdef UART_RX_MAJORITY_EN
    exp_d = 8'hA5;
`else
    exp_d = 8'hA1;
`endif
    send_frame(8'hA5, 1'b1, HALF + 3 * CYCLE, -1, sc);
    repeat (2) @(negedge clk);
    checks++; if (rx_if.data !== exp_d) begin errors++; $display("FAIL glitch_data got %h exp %h", rx_if.data, exp_d); end
  endtask

  initial begin
    rx_if.rx_pin = 1'b1;
    test_reset();
    test_loopback();
    test_back_to_back();
    test_false_start();
    test_frame_error();
    test_reset_mid_frame();
    test_glitch();
    checks++; if (n_both != 0) begin errors++; $display("FAIL pulse_overlap got %0d exp 0", n_both); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
